opc6_busctl: RTL

- Bus controller for the OPC6 system. Sits between the opc6cpu core, a secondary DMA requester (video/loader) and the single shared 16-bit memory/IO bus.
- Arbitrates the bus between the two requesters and inserts per-space wait states.
- Generates the CPU clken stall, replacing ad-hoc wait-state logic in system tops.
- DMA accesses memory space only.

---
 rtl/opc6_busctl.sv | 118 +++++++++++
 1 files changed

// File: rtl/opc6_busctl.sv
// opc6_busctl: arbitrates the shared OPC6 memory/IO bus between the CPU and a DMA requester,
// inserting per-space wait states and generating the CPU clock-enable stall.
module opc6_busctl #(
    parameter int MEM_WAIT = 1,
    parameter int IO_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_rnw,
    input  logic        cpu_vpa,
    input  logic        cpu_vda,
    input  logic        cpu_vio,
    output logic [15:0] cpu_din,
    output logic        cpu_clken,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_rnw,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        mem_cs_b,
    output logic        io_cs_b,
    output logic        bus_we_b,
    output logic        bus_oe_b
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_ACC = 2'd1;
    localparam logic [1:0] DMA_ACC = 2'd2;
    localparam logic [3:0] MW = 4'(MEM_WAIT);
    localparam logic [3:0] IW = 4'(IO_WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_dma_q, last_dma_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        rnw_q, rnw_d, io_q, io_d, ack_q;
    logic        cpu_req, cpu_win, acc, done;

    assign cpu_req = cpu_vpa | cpu_vda | cpu_vio;
    // Alternating priority: DMA wins a tie unless it owned the previous access
    assign cpu_win = cpu_req && !(dma_req && !last_dma_q);
    assign acc     = state_q != IDLE;
    assign done    = acc && cnt_q == 4'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dma_d = last_dma_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rnw_d      = rnw_q;
        io_d       = io_q;
        rdata_d    = rdata_q;
        if (!acc) begin
            if (cpu_win) begin
                state_d = CPU_ACC;
                cnt_d   = cpu_vio ? IW : MW;
                addr_d  = cpu_addr;
                wdata_d = cpu_dout;
                rnw_d   = cpu_rnw;
                io_d    = cpu_vio;
            end else if (dma_req) begin
                state_d = DMA_ACC;
                cnt_d   = MW;
                addr_d  = dma_addr;
                wdata_d = dma_wdata;
                rnw_d   = dma_rnw;
                io_d    = 1'b0;
            end
        end else if (done) begin
            state_d    = IDLE;
            last_dma_d = state_q == DMA_ACC;
            rdata_d    = (state_q == DMA_ACC && rnw_q) ? bus_rdata : rdata_q;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_dma_q <= 1'b0;
            addr_q     <= 16'h0;
            wdata_q    <= 16'h0;
            rnw_q      <= 1'b1;
            io_q       <= 1'b0;
            rdata_q    <= 16'h0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dma_q <= last_dma_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rnw_q      <= rnw_d;
            io_q       <= io_d;
            rdata_q    <= rdata_d;
            ack_q      <= done && state_q == DMA_ACC;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign mem_cs_b  = !(acc && !io_q);
    assign io_cs_b   = !(acc && io_q);
    assign bus_oe_b  = !(acc && rnw_q);
    assign bus_we_b  = !(acc && !rnw_q);
    assign cpu_clken = !cpu_req || (state_q == CPU_ACC && cnt_q == 4'd0);
    assign cpu_din   = bus_rdata;
    assign dma_ack   = ack_q;
    assign dma_rdata = rdata_q;
endmodule
